// File: rtl/sap_ram_loader_if.sv
// ============================================================================
// Module  : sap_ram_loader_if
// Purpose : command, byte-source and shared RAM bus signals of the loader.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface sap_ram_loader_if;
  logic       start;
  logic       verify_en;
  logic       abort;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] bus_out;
  logic       bus_drive;
  logic [7:0] bus_in;
  logic       ram_ae;
  logic       ram_we;
  logic       ram_oe;
  logic       cpu_hold;
  logic       busy;
  logic       done;
  logic       error;
  logic [3:0] err_addr;
  logic [4:0] load_count;

  // Controller / environment side: issues commands, supplies bytes, closes the bus.
  modport master (
    output start, verify_en, abort, in_data, in_valid, bus_in,
    input  in_ready, bus_out, bus_drive, ram_ae, ram_we, ram_oe,
    input  cpu_hold, busy, done, error, err_addr, load_count
  );

  // Loader side.
  modport slave (
    input  start, verify_en, abort, in_data, in_valid, bus_in,
    output in_ready, bus_out, bus_drive, ram_ae, ram_we, ram_oe,
    output cpu_hold, busy, done, error, err_addr, load_count
  );
endinterface

`default_nettype wire

// File: rtl/sap_ram_loader.sv
// ============================================================================
// Module  : sap_ram_loader
// Purpose : loads a byte stream into the SAP 16x8 RAM over the shared bus,
//           with optional readback verify.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sap_ram_loader #(
  parameter int LOAD_WORDS = 16,
  parameter int BASE_ADDR  = 0
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  sap_ram_loader_if.slave lif
);

  localparam logic [3:0] c_last_idx = 4'(LOAD_WORDS - 1);
  localparam logic [3:0] c_base     = 4'(BASE_ADDR);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_DATA = 3'd1,
    S_SET_ADDR  = 3'd2,
    S_WRITE     = 3'd3,
    S_RB_ADDR   = 3'd4,
    S_RB_READ   = 3'd5,
    S_DONE      = 3'd6
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] addr_q, addr_d;
  logic [3:0] idx_q, idx_d;
  logic [7:0] hold_q, hold_d;
  logic       verify_q, verify_d;
  logic       error_q, error_d;
  logic [3:0] err_addr_q, err_addr_d;
  logic [4:0] load_count_q, load_count_d;
  logic [7:0] shadow_q [16];
  logic [7:0] shadow_d [16];

  logic w_busy;
  logic w_last;

  assign w_busy = (state_q != S_IDLE) && (state_q != S_DONE);
  assign w_last = (idx_q == c_last_idx);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    idx_d        = idx_q;
    hold_d       = hold_q;
    verify_d     = verify_q;
    error_d      = error_q;
    err_addr_d   = err_addr_q;
    load_count_d = load_count_q;
    shadow_d     = shadow_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (lif.start && !lif.abort) begin
          verify_d     = lif.verify_en;
          addr_d       = c_base;
          idx_d        = 4'd0;
          load_count_d = 5'd0;
          error_d      = 1'b0;
          err_addr_d   = 4'd0;
          state_d      = S_WAIT_DATA;
        end
      end
      S_WAIT_DATA: begin
        if (lif.in_valid && !lif.abort) begin
          hold_d          = lif.in_data;
          shadow_d[idx_q] = lif.in_data;
          state_d         = S_SET_ADDR;
        end
      end
      S_SET_ADDR: state_d = S_WRITE;
      S_WRITE: begin
        // The write strobe is already on the bus this cycle, so it counts even if aborted.
        load_count_d = load_count_q + 5'd1;
        if (w_last) begin
          if (verify_q) begin
            addr_d  = c_base;
            idx_d   = 4'd0;
            state_d = S_RB_ADDR;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          addr_d  = addr_q + 4'd1;
          idx_d   = idx_q + 4'd1;
          state_d = S_WAIT_DATA;
        end
      end
      S_RB_ADDR: state_d = S_RB_READ;
      S_RB_READ: begin
        if ((lif.bus_in != shadow_q[idx_q]) && !error_q) begin
          error_d    = 1'b1;
          err_addr_d = addr_q;
        end
        if (w_last) begin
          state_d = S_DONE;
        end else begin
          addr_d  = addr_q + 4'd1;
          idx_d   = idx_q + 4'd1;
          state_d = S_RB_ADDR;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (w_busy && lif.abort) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      addr_q       <= 4'd0;
      idx_q        <= 4'd0;
      hold_q       <= 8'd0;
      verify_q     <= 1'b0;
      error_q      <= 1'b0;
      err_addr_q   <= 4'd0;
      load_count_q <= 5'd0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      idx_q        <= idx_d;
      hold_q       <= hold_d;
      verify_q     <= verify_d;
      error_q      <= error_d;
      err_addr_q   <= err_addr_d;
      load_count_q <= load_count_d;
    end
  end

  // Shadow copy is only read after being written in the same run; no reset needed.
  always_ff @(posedge clk) begin
    shadow_q <= shadow_d;
  end

  // Bus and strobes decode from state and registers only.
  assign lif.in_ready   = (state_q == S_WAIT_DATA);
  assign lif.ram_ae     = (state_q == S_SET_ADDR) || (state_q == S_RB_ADDR);
  assign lif.ram_we     = (state_q == S_WRITE);
  assign lif.ram_oe     = (state_q == S_RB_READ);
  assign lif.bus_drive  = lif.ram_ae || lif.ram_we;
  assign lif.bus_out    = lif.ram_ae ? {4'b0000, addr_q} :
                          lif.ram_we ? hold_q : 8'h00;
  assign lif.busy       = w_busy;
  assign lif.cpu_hold   = w_busy;
  assign lif.done       = (state_q == S_DONE);
  assign lif.error      = error_q;
  assign lif.err_addr   = err_addr_q;
  assign lif.load_count = load_count_q;

endmodule

`default_nettype wire
